// File: rtl/line_tracker_fsm.sv
// Line-follower decision stage: IR sensor sync/debounce, tracking FSM and motor mode command.
// Optional reverse-before-pivot recovery is enabled by defining TRACK_BACKUP_EN.
module line_tracker_fsm #(
    parameter int unsigned DEBOUNCE       = 1000,
    parameter int unsigned SEARCH_TIMEOUT = 50_000_000,
    parameter int unsigned BACKUP_CYCLES  = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] sensor,
    output logic [2:0] mode,
    output logic [1:0] state,
    output logic       lost
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SENS_W = 3;
    localparam int unsigned MODE_W = 3;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(SEARCH_TIMEOUT - 1);

    localparam logic [MODE_W-1:0] M_STOP    = 3'b000;
    localparam logic [MODE_W-1:0] M_PIVOT_L = 3'b001;
    localparam logic [MODE_W-1:0] M_PIVOT_R = 3'b010;
    localparam logic [MODE_W-1:0] M_FWD     = 3'b011;
    localparam logic [MODE_W-1:0] M_BACK    = 3'b100;
    localparam logic [MODE_W-1:0] M_VEER_L  = 3'b101;
    localparam logic [MODE_W-1:0] M_VEER_R  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_SEARCH = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    // Reject parameter values that would make a counter limit underflow.
    if (DEBOUNCE < 1 || SEARCH_TIMEOUT < 1 || BACKUP_CYCLES < 1) begin : g_bad_param
        $error("line_tracker_fsm: DEBOUNCE, SEARCH_TIMEOUT and BACKUP_CYCLES must be >= 1");
    end

    logic [SENS_W-1:0] sync1;
    logic [SENS_W-1:0] sync2;
    logic [SENS_W-1:0] filt;
    logic [CNT_W-1:0]  db_cnt [SENS_W];

    state_t            state_q;
    logic              last_side;
    logic [CNT_W-1:0]  scnt;

`ifdef TRACK_BACKUP_EN
    localparam logic [CNT_W-1:0] BK_LIMIT = CNT_W'(BACKUP_CYCLES - 1);
    logic              backing;
    logic [CNT_W-1:0]  bcnt;
`endif

    function automatic logic [MODE_W-1:0] pivot(input logic side);
        return side ? M_PIVOT_R : M_PIVOT_L;
    endfunction

    function automatic logic [MODE_W-1:0] steer(input logic [SENS_W-1:0] fv, input logic side);
        case (fv)
            3'b110:  return M_VEER_L;
            3'b011:  return M_VEER_R;
            3'b100:  return M_PIVOT_L;
            3'b001:  return M_PIVOT_R;
            3'b000:  return pivot(side);
            default: return M_FWD;
        endcase
    endfunction

    function automatic logic next_side(input logic [SENS_W-1:0] fv, input logic side);
        case (fv)
            3'b100, 3'b110: return 1'b0;
            3'b001, 3'b011: return 1'b1;
            default:        return side;
        endcase
    endfunction

    // Two-flop synchronizer followed by a per-bit persistence filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < SENS_W; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
            for (int i = 0; i < SENS_W; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LIMIT) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Tracking FSM; mode is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode      <= M_STOP;
            lost      <= 1'b0;
            last_side <= 1'b0;
            scnt      <= '0;
`ifdef TRACK_BACKUP_EN
            backing   <= 1'b0;
            bcnt      <= '0;
`endif
        end else if (stop) begin
            state_q <= S_IDLE;
            mode    <= M_STOP;
            lost    <= 1'b0;
            scnt    <= '0;
`ifdef TRACK_BACKUP_EN
            backing <= 1'b0;
            bcnt    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    mode <= M_STOP;
                    lost <= 1'b0;
                    if (start) begin
                        state_q <= S_TRACK;
                        mode    <= steer(filt, last_side);
                    end
                end

                S_TRACK: begin
                    last_side <= next_side(filt, last_side);
                    if (filt == '0) begin
                        state_q <= S_SEARCH;
                        scnt    <= '0;
`ifdef TRACK_BACKUP_EN
                        backing <= 1'b1;
                        bcnt    <= '0;
                        mode    <= M_BACK;
`else
                        mode    <= pivot(last_side);
`endif
                    end else begin
                        mode <= steer(filt, last_side);
                    end
                end

                S_SEARCH: begin
                    if (filt != '0) begin
                        // Reacquiring the line beats a simultaneous timeout.
                        state_q <= S_TRACK;
                        mode    <= steer(filt, last_side);
                        scnt    <= '0;
`ifdef TRACK_BACKUP_EN
                        backing <= 1'b0;
                        bcnt    <= '0;
`endif
                    end
`ifdef TRACK_BACKUP_EN
                    else if (backing) begin
                        if (bcnt == BK_LIMIT) begin
                            backing <= 1'b0;
                            bcnt    <= '0;
                            mode    <= pivot(last_side);
                        end else begin
                            bcnt <= bcnt + CNT_W'(1);
                            mode <= M_BACK;
                        end
                    end
`endif
                    else if (scnt == TO_LIMIT) begin
                        state_q <= S_HALT;
                        mode    <= M_STOP;
                        lost    <= 1'b1;
                        scnt    <= '0;
                    end else begin
                        scnt <= scnt + CNT_W'(1);
                        mode <= pivot(last_side);
                    end
                end

                S_HALT: begin
                    mode <= M_STOP;
                    lost <= 1'b1;
                    if (start) begin
                        state_q   <= S_TRACK;
                        lost      <= 1'b0;
                        last_side <= 1'b0;
                        mode      <= steer(filt, 1'b0);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    mode    <= M_STOP;
                    lost    <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_line_tracker_fsm.sv
// Directed self-checking bench for line_tracker_fsm (DEBOUNCE=4, SEARCH_TIMEOUT=100, BACKUP_CYCLES=20).
module tb_line_tracker_fsm;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 100;
    localparam int unsigned BKC = 20;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [2:0] sensor;
    logic [2:0] mode;
    logic [1:0] state;
    logic       lost;

    int n_checks;
    int n_fail;

    line_tracker_fsm #(
        .DEBOUNCE       (DEB),
        .SEARCH_TIMEOUT (TMO),
        .BACKUP_CYCLES  (BKC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .sensor (sensor),
        .mode   (mode),
        .state  (state),
        .lost   (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sens;
        int         hold;
        logic [2:0] exp_mode;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [1:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == exp) break;
            @(negedge clk);
        end
        check(name, 32'(state), 32'(exp));
    endtask

    int lat;
    int n_pivot;
    int n_back;
    int exp_back;
    logic [2:0] exp_search_mode;
    logic saw_lost;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef TRACK_BACKUP_EN
        exp_back        = int'(BKC);
        exp_search_mode = 3'b100;
`else
        exp_back        = 0;
        exp_search_mode = 3'b001;
`endif

        vecs[0] = '{sens: 3'b110, hold: 20, exp_mode: 3'b101};
        vecs[1] = '{sens: 3'b011, hold: 20, exp_mode: 3'b110};
        vecs[2] = '{sens: 3'b100, hold: 20, exp_mode: 3'b001};
        vecs[3] = '{sens: 3'b001, hold: 20, exp_mode: 3'b010};
        vecs[4] = '{sens: 3'b111, hold: 20, exp_mode: 3'b011};
        vecs[5] = '{sens: 3'b101, hold: 20, exp_mode: 3'b011};
        vecs[6] = '{sens: 3'b010, hold: 20, exp_mode: 3'b011};

        reset = 1'b1; start = 1'b0; stop = 1'b0; sensor = 3'b000;
        cycles(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_mode",  32'(mode),  32'd0);
        check("reset_lost",  32'(lost),  32'd0);
        reset = 1'b0;

        // Reset then start with the line centred.
        sensor = 3'b010;
        cycles(12);
        check("idle_mode", 32'(mode), 32'd0);
        pulse_start();
        check("start_state", 32'(state), 32'd1);
        check("start_mode",  32'(mode),  32'b011);
        check("start_lost",  32'(lost),  32'd0);

        // Sensor-to-mode latency: 2 sync + DEB + 1 filter + 1 mode edges.
        sensor = 3'b110;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (mode == 3'b101) break;
        end
        check("latency", 32'(lat), 32'(DEB + 4));

        // Steering map table.
        foreach (vecs[k]) begin
            sensor = vecs[k].sens;
            cycles(vecs[k].hold);
            check($sformatf("steer_%03b", vecs[k].sens), 32'(mode), 32'(vecs[k].exp_mode));
            check($sformatf("steer_state_%03b", vecs[k].sens), 32'(state), 32'd1);
        end

        // A 3-cycle dropout never reaches the filtered vector.
        sensor = 3'b000;
        cycles(3);
        sensor = 3'b010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("glitch_mode", 32'(mode), 32'b011);
        end

        // start while tracking is ignored.
        pulse_start();
        check("start_in_track", 32'(state), 32'd1);

        // Recovery: lose the line on the left, reacquire after 50 cycles.
        sensor = 3'b100;
        cycles(20);
        sensor = 3'b000;
        wait_state("enter_search", 2'd2, 20);
        check("search_mode", 32'(mode), 32'(exp_search_mode));
        saw_lost = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            saw_lost |= lost;
        end
        check("search_still", 32'(state), 32'd2);
        check("search_pivot_l", 32'(mode), 32'b001);
        sensor = 3'b010;
        for (int i = 0; i < 20 && state == 2'd2; i++) begin
            @(negedge clk);
            saw_lost |= lost;
        end
        check("recover_state", 32'(state), 32'd1);
        check("recover_mode",  32'(mode),  32'b011);
        check("recover_nolost", 32'(saw_lost), 32'd0);

        // Timeout: line last seen on the right.
        sensor = 3'b001;
        cycles(20);
        sensor = 3'b000;
        wait_state("to_enter_search", 2'd2, 20);
        n_pivot = 0;
        n_back  = 0;
        for (int i = 0; i < 400 && state == 2'd2; i++) begin
            if (mode == 3'b010) n_pivot++;
            if (mode == 3'b100) n_back++;
            @(negedge clk);
        end
        check("to_pivot_cycles", 32'(n_pivot), 32'(TMO));
        check("to_back_cycles",  32'(n_back),  32'(exp_back));
        check("halt_state", 32'(state), 32'd3);
        check("halt_mode",  32'(mode),  32'd0);
        check("halt_lost",  32'(lost),  32'd1);

        // Restart from HALT with no line: last_side was cleared to left.
        pulse_start();
        check("halt_restart_state", 32'(state), 32'd1);
        check("halt_restart_lost",  32'(lost),  32'd0);
        cycles(1);
        check("relost_state", 32'(state), 32'd2);
        check("relost_mode",  32'(mode),  32'(exp_search_mode));
        wait_state("second_halt", 2'd3, 400);

        // Sensor activity in HALT does not leave HALT; start does.
        sensor = 3'b010;
        cycles(12);
        check("halt_hold", 32'(state), 32'd3);
        pulse_start();
        check("restart_state", 32'(state), 32'd1);
        check("restart_mode",  32'(mode),  32'b011);
        check("restart_lost",  32'(lost),  32'd0);

        // start and stop together: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("prio_state", 32'(state), 32'd0);
        check("prio_mode",  32'(mode),  32'd0);
        pulse_start();
        check("prio_restart", 32'(state), 32'd1);

        // Asynchronous reset in the middle of SEARCH.
        sensor = 3'b000;
        wait_state("pre_reset_search", 2'd2, 20);
        cycles(5);
        #2;
        reset = 1'b1;
        #1;
        check("areset_state", 32'(state), 32'd0);
        check("areset_mode",  32'(mode),  32'd0);
        check("areset_lost",  32'(lost),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycles(3);
        check("post_reset_idle", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
